pio_ext: RTL and testbench



---
 rtl/pio_pkg.sv | 23 ++
 rtl/pio_edge_capture.sv | 58 +++++
 rtl/pio_ext.sv | 90 +++++++++
 tb/tb_pio_ext.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// ============================================================================
// Module      : pio_pkg
// Description : Shared register map and edge-type encodings for pio_ext.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_OUTDATA  = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

`default_nettype wire

// File: rtl/pio_edge_capture.sv
// ============================================================================
// Module      : pio_edge_capture
// Description : Two-flop input synchroniser, edge detect and sticky capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_edge_capture
    import pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned EDGE_TYPE  = EDGE_RISING
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic [DATA_WIDTH-1:0] i_clear,
    output logic [DATA_WIDTH-1:0] o_in_sync,
    output logic [DATA_WIDTH-1:0] o_edge_cap
);

    logic [DATA_WIDTH-1:0] r_s1;
    logic [DATA_WIDTH-1:0] r_in_sync;
    logic [DATA_WIDTH-1:0] r_in_prev;
    logic [DATA_WIDTH-1:0] r_edge_cap;
    logic [DATA_WIDTH-1:0] w_edge;

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
            assign w_edge = ~r_in_sync & r_in_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign w_edge = r_in_sync ^ r_in_prev;
        end else begin : g_rising
            assign w_edge = r_in_sync & ~r_in_prev;
        end
    endgenerate

    // A fresh edge beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1       <= '0;
            r_in_sync  <= '0;
            r_in_prev  <= '0;
            r_edge_cap <= '0;
        end else begin
            r_s1       <= i_in;
            r_in_sync  <= r_s1;
            r_in_prev  <= r_in_sync;
            r_edge_cap <= w_edge | (r_edge_cap & ~i_clear);
        end
    end

    assign o_in_sync  = r_in_sync;
    assign o_edge_cap = r_edge_cap;

endmodule

`default_nettype wire

// File: rtl/pio_ext.sv
// ============================================================================
// Module      : pio_ext
// Description : Parametrised Avalon-MM GPIO with set/clear, edge capture, IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_ext
    import pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned EDGE_TYPE   = EDGE_RISING,
    parameter bit          IRQ_ENABLE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] r_irqmask;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_clear;
    logic [DATA_WIDTH-1:0] w_in_sync;
    logic [DATA_WIDTH-1:0] w_edge_cap;
    logic [31:0]           w_readdata;
    logic                  w_wr;
    logic                  w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[DATA_WIDTH-1:0];
    assign w_unused_wdata = ^writedata;
    assign w_clear        = (w_wr && address == ADDR_EDGECAP) ? w_wdata : '0;
    assign w_mask         = IRQ_ENABLE ? r_irqmask : '0;

    pio_edge_capture #(
        .DATA_WIDTH (DATA_WIDTH),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_edge_capture (
        .clk        (clk),
        .reset      (reset),
        .i_in       (in_port),
        .i_clear    (w_clear),
        .o_in_sync  (w_in_sync),
        .o_edge_cap (w_edge_cap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out     <= RESET_VALUE[DATA_WIDTH-1:0];
            r_irqmask <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA, ADDR_OUTDATA: r_out     <= w_wdata;
                ADDR_IRQMASK:            r_irqmask <= w_wdata;
                ADDR_OUTSET:             r_out     <= r_out | w_wdata;
                ADDR_OUTCLEAR:           r_out     <= r_out & ~w_wdata;
                default:                 ;
            endcase
        end
    end

    // Read path ignores chipselect; reads have no side effects.
    always_comb begin
        w_readdata = '0;
        case (address)
            ADDR_DATA:    w_readdata = 32'(w_in_sync);
            ADDR_OUTDATA: w_readdata = 32'(r_out);
            ADDR_IRQMASK: w_readdata = 32'(w_mask);
            ADDR_EDGECAP: w_readdata = 32'(w_edge_cap);
            default:      w_readdata = '0;
        endcase
    end

    assign readdata = w_readdata;
    assign out_port = r_out;
    assign irq      = |(w_edge_cap & w_mask);

endmodule

`default_nettype wire

// File: tb/tb_pio_ext.sv
// ============================================================================
// Module      : tb_pio_ext
// Description : Directed self-checking bench for pio_ext (8-bit, rising edge).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pio_ext;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic        irq;

    int n_compared   = 0;
    int n_mismatched = 0;

    pio_ext #(
        .DATA_WIDTH  (8),
        .RESET_VALUE (32'hA5),
        .EDGE_TYPE   (0),
        .IRQ_ENABLE  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic wait_clocks(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        #22;
        check("reset_out_port", 32'(out_port), 32'hA5);
        check("reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        do_read("rd_outdata_reset", 3'd1, 32'h0000_00A5);
        do_read("rd_irqmask_reset", 3'd2, 32'h0);

        // Output path: DATA write, set, clear.
        do_write(3'd0, 32'hFFFF_FF3C);
        check("wr_data_out", 32'(out_port), 32'h3C);
        do_write(3'd4, 32'h81);
        check("outset", 32'(out_port), 32'hBD);
        do_write(3'd5, 32'h0C);
        check("outclear", 32'(out_port), 32'hB1);
        do_read("rd_outset_zero", 3'd4, 32'h0);
        do_read("rd_outdata", 3'd1, 32'hB1);

        // Input edge capture: latency of three clock edges.
        @(negedge clk);
        in_port = 8'h12;
        address = 3'd3;
        wait_clocks(2);
        check("edgecap_2clk", readdata, 32'h0);
        wait_clocks(1);
        check("edgecap_3clk", readdata, 32'h12);
        @(negedge clk);
        in_port = 8'h00;
        wait_clocks(5);
        do_read("edgecap_sticky", 3'd3, 32'h12);
        do_read("rd_data_insync", 3'd0, 32'h0);

        // Interrupt masking and write-1-to-clear.
        do_write(3'd2, 32'h02);
        check("irq_masked_on", 32'(irq), 32'h1);
        do_read("rd_irqmask", 3'd2, 32'h02);
        do_write(3'd3, 32'h02);
        check("clear_edgecap", readdata, 32'h10);
        check("irq_cleared", 32'(irq), 32'h0);
        do_write(3'd3, 32'h10);
        check("clear_bit4", readdata, 32'h0);

        // New edge and clear on the same edge: the edge wins.
        @(negedge clk);
        in_port = 8'h10;
        @(posedge clk);
        @(posedge clk);
        do_write(3'd3, 32'h10);
        check("edge_beats_clear", readdata, 32'h10);
        do_write(3'd2, 32'h10);
        check("irq_bit4", 32'(irq), 32'h1);
        do_write(3'd3, 32'h10);
        check("irq_bit4_cleared", 32'(irq), 32'h0);

        // Unmapped addresses.
        do_write(3'd7, 32'hFF);
        check("wr_addr7_ignored", 32'(out_port), 32'hB1);
        do_read("rd_addr6", 3'd6, 32'h0);

        // Load everything up, then reset asynchronously mid-write.
        @(negedge clk);
        in_port = 8'h00;
        wait_clocks(4);
        do_write(3'd1, 32'hFF);
        do_write(3'd2, 32'hFF);
        @(negedge clk);
        in_port = 8'hFF;
        wait_clocks(4);
        do_read("edgecap_all", 3'd3, 32'hFF);
        check("irq_all", 32'(irq), 32'h1);
        @(negedge clk);
        address    = 3'd3;
        writedata  = 32'h0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_out_port", 32'(out_port), 32'hA5);
        check("async_edgecap", readdata, 32'h0);
        check("async_irq", 32'(irq), 32'h0);
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_read("irqmask_after_reset", 3'd2, 32'h0);

        // Input held high through reset shows up as a rising edge.
        address = 3'd3;
        wait_clocks(2);
        check("post_reset_edge", readdata, 32'hFF);
        check("post_reset_irq", 32'(irq), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire
